// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared states, opcodes and control encodings for the multicycle controller
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluop/funct3/op[5]/funct7b5 onto the ALU operation select
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op[5]=1) can encode sub; addi with bit30 set stays add
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I Moore control FSM; MCCTRL_BNE_EN adds bne
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       regwrite,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol
);

  state_t     state, state_next;
  logic       pcupdate, branch, taken, is_branch;
  logic       adrsrc_s, memwrite_s, irwrite_s, regwrite_s;
  logic [1:0] resultsrc_s, alusrca_s, alusrcb_s, aluop, imm_dec;
  logic [2:0] alu_dec;

`ifdef MCCTRL_BNE_EN
  assign is_branch = (op == OP_BEQ) && ((funct3 == 3'b000) || (funct3 == 3'b001));
  assign taken     = funct3[0] ? ~zero : zero;
`else
  assign is_branch = (op == OP_BEQ) && (funct3 == 3'b000);
  assign taken     = zero;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = S_FETCH;
    pcupdate    = 1'b0;
    branch      = 1'b0;
    adrsrc_s    = 1'b0;
    memwrite_s  = 1'b0;
    irwrite_s   = 1'b0;
    regwrite_s  = 1'b0;
    resultsrc_s = 2'b00;
    alusrca_s   = 2'b00;
    alusrcb_s   = 2'b00;
    aluop       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        irwrite_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        pcupdate    = 1'b1;
        state_next  = S_DECODE;
      end
      S_DECODE: begin
        alusrca_s = 2'b01;
        alusrcb_s = 2'b01;
        if (op == OP_LW || op == OP_SW) state_next = S_MEMADR;
        else if (op == OP_RTYPE)        state_next = S_EXECUTER;
        else if (op == OP_IALU)         state_next = S_EXECUTEI;
        else if (is_branch)             state_next = S_BEQ;
        else if (op == OP_JAL)          state_next = S_JAL;
        else                            state_next = S_FETCH;
      end
      S_MEMADR: begin
        alusrca_s  = 2'b10;
        alusrcb_s  = 2'b01;
        state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc_s   = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_s   = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTER: begin
        alusrca_s  = 2'b10;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca_s  = 2'b10;
        alusrcb_s  = 2'b01;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: regwrite_s = 1'b1;
      S_BEQ: begin
        alusrca_s = 2'b10;
        aluop     = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alusrca_s  = 2'b01;
        alusrcb_s  = 2'b10;
        pcupdate   = 1'b1;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_dec = IMM_S;
      OP_BEQ:  imm_dec = IMM_B;
      OP_JAL:  imm_dec = IMM_J;
      default: imm_dec = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alu_dec)
  );

  // reset low silences every output so nothing is written while the FSM is being forced to FETCH
  assign pcwrite    = reset & (pcupdate | (branch & taken));
  assign adrsrc     = reset & adrsrc_s;
  assign memwrite   = reset & memwrite_s;
  assign irwrite    = reset & irwrite_s;
  assign regwrite   = reset & regwrite_s;
  assign resultsrc  = reset ? resultsrc_s : 2'b00;
  assign alusrca    = reset ? alusrca_s   : 2'b00;
  assign alusrcb    = reset ? alusrcb_s   : 2'b00;
  assign immsrc     = reset ? imm_dec     : 2'b00;
  assign alucontrol = reset ? alu_dec     : 3'b000;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle RV32I datapath. Decodes `op`/`funct3`/`funct7b5` and sequences fetch, decode, execute, memory and writeback, one datapath step per cycle. Drives `immsrc` to the immediate extender, the datapath muxes and the ALU control. Write enables go to the PC, IR, register file and memory.

## Interface
- Parameters: none.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low; 0 at a rising edge resets the block.
- `op` in 7: instr[6:0] from IR.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `pcwrite` out 1: PC register enable.
- `adrsrc` out 1: memory address select; 0 = PC, 1 = ALUOut/result.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: IR and OldPC enable.
- `resultsrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult.
- `alusrca` out 2: 00 PC, 01 OldPC, 10 rs1 register.
- `alusrcb` out 2: 00 rs2 register, 01 immext, 10 constant 4.
- `regwrite` out 1: register file write enable.
- `immsrc` out 2: extender select; 00 I, 01 S, 10 B, 11 J.
- `alucontrol` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.

## Operation
- **Moore FSM.** Each state's outputs are listed below; any field not listed is 0. `aluop` is internal.
  - FETCH: irwrite, alusrcb=10, resultsrc=10, pcupdate. Next state: DECODE.
  - DECODE: alusrca=01, alusrcb=01. Computes the branch target into ALUOut.
    - lw/sw → MEMADR; R-type → EXECUTER; I-ALU → EXECUTEI; beq → BEQ; jal → JAL.
    - Any other opcode → FETCH, with no write enables asserted.
  - MEMADR: alusrca=10, alusrcb=01. Next: MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD: adrsrc=1. Next: MEMWB.
  - MEMWB: resultsrc=01, regwrite. Next: FETCH.
  - MEMWRITE: adrsrc=1, memwrite. Next: FETCH.
  - EXECUTER: alusrca=10, aluop=10. Next: ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=10. Next: ALUWB.
  - ALUWB: regwrite. Next: FETCH.
  - BEQ: alusrca=10, aluop=01, branch. Next: FETCH.
  - JAL: alusrca=01, alusrcb=10, pcupdate. Next: ALUWB.
- **Opcodes:** lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- **pcwrite** = pcupdate | (branch & taken). Without the macro, taken = `zero`.
- **immsrc** is combinational from `op` in every state:
  - lw and I-ALU → 00; sw → 01; beq → 10; jal → 11.
  - R-type and unsupported opcodes → 00.
- **ALU decode:**
  - aluop 00 → add; aluop 01 → sub.
  - aluop 10, by `funct3`:
    - 000 → sub if op[5] & funct7b5, else add.
    - 010 → slt; 110 → or; 111 → and.
    - Any other value → add.
- **Reset:**
  - `reset`=0 at a rising edge sets state to FETCH, from any state, including mid-instruction.
  - While `reset`=0, all outputs are forced to 0 combinationally. No stray IR, PC, register or memory writes occur.
  - The first cycle after release is FETCH.

## Timing
- Outputs change only on state transitions, except `immsrc`, which follows `op`.
- Cycles per instruction, counting FETCH as cycle 1:
  - lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, unsupported 2.
- Writes by instruction:
  - lw: regwrite in cycle 5.
  - sw: memwrite in cycle 4.
  - beq: pcwrite in cycle 3 if taken.
  - jal: pcwrite in cycle 3, regwrite in cycle 4.
- `zero` is sampled combinationally during BEQ only.
- There is no handshake: memory is single-cycle and the controller never stalls.

## Configuration
- `MCCTRL_BNE_EN` defined:
  - Opcode 1100011 with funct3 001 (bne) also goes to BEQ, with taken = ~`zero`.
  - funct3 000 keeps taken = `zero`.
  - Any other funct3 under 1100011 takes DECODE → FETCH.
- `MCCTRL_BNE_EN` undefined: only funct3 000 is a branch; every other funct3 under 1100011 is unsupported.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum;
  - the opcode constants;
  - the `immsrc`, `alucontrol` and `aluop` encodings.
- Sub-module `alu_decoder`: combinational `aluop`/`funct3`/op[5]/`funct7b5` → `alucontrol`. The FSM and the immsrc decode live in the top module.

## Test plan
- IR=ffc3a303 (lw x6,-4(x7)) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. immsrc=00, regwrite=1 only in cycle 5, resultsrc=01.
- IR=01d3a423 (sw) → immsrc=01, memwrite=1 and adrsrc=1 in cycle 4, regwrite never asserted.
- IR=000e8e63 (beq): zero=1 → pcwrite=1 in cycle 3, alucontrol=001, immsrc=10. zero=0 → pcwrite=0 in cycle 3.
- IR=008000ef (jal x1,8) → immsrc=11, pcwrite=1 in cycles 1 and 3, regwrite=1 in cycle 4 with resultsrc=00.
- R-type sub (op 0110011, funct3 000, funct7b5=1) → alucontrol=001 in EXECUTER. Same encoding with op 0010011 (addi) → 000.
- Reset asserted during MEMREAD:
  - All outputs are 0 while reset=0.
  - After release, the first state is FETCH with irwrite=1.
- Unsupported opcode 0000000 → FETCH, DECODE, FETCH with no writes.
- With `MCCTRL_BNE_EN` defined, bne (funct3 001) and zero=0 → pcwrite=1 in cycle 3.
